route_ctrl: RTL and testbench

- Per-input-port control stage directly downstream of the input buffer.
- Pops flits from the buffer and decodes the head flit's destination with XY routing.
- Requests and holds one output port (wormhole lock) until the tail flit leaves.
- Forwards every flit of the packet through a one-entry registered valid/ready output toward the crossbar.

---
 rtl/route_ctrl_if.sv | 27 ++
 rtl/route_ctrl.sv | 160 ++++++++++++++++
 tb/tb_route_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_ctrl_if.sv
// Bundles the buffer-side, allocator-side and crossbar-side signals of one
// route_ctrl instance; the slave modport is the controller's view.
interface route_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 8
);
    logic                  buf_empty_i;
    logic [DATA_WIDTH-1:0] buf_data_i;
    logic                  buf_read_o;
    logic [4:0]            req_o;
    logic [4:0]            gnt_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  busy_o;
    logic [CNT_W-1:0]      drop_cnt_o;

    modport slave (
        input  buf_empty_i, buf_data_i, gnt_i, out_ready_i,
        output buf_read_o, req_o, out_data_o, out_valid_o, busy_o, drop_cnt_o
    );

    modport master (
        output buf_empty_i, buf_data_i, gnt_i, out_ready_i,
        input  buf_read_o, req_o, out_data_o, out_valid_o, busy_o, drop_cnt_o
    );
endinterface

// File: rtl/route_ctrl.sv
// Input-port route controller: pops flits, XY-routes the head, holds the
// output-port request for the whole packet and forwards through a 1-entry register.
module route_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int COORD_W    = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    route_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_FWD   = 2'd2
    } state_t;

    localparam logic [1:0] TY_SINGLE = 2'b00;
    localparam logic [1:0] TY_TAIL   = 2'b11;
    localparam logic [COORD_W-1:0] LP_MY_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] LP_MY_Y = COORD_W'(MY_Y);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    function automatic logic is_head(input logic [1:0] t);
        return (t[1] == 1'b0);
    endfunction

    function automatic logic is_last(input logic [1:0] t);
        return (t == TY_SINGLE) || (t == TY_TAIL);
    endfunction

    // One-hot port order: L, N, E, S, W; X is resolved before Y.
    function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx,
                                            input logic [COORD_W-1:0] dy);
        logic [4:0] port;
        if (dx > LP_MY_X)      port = 5'b00100;
        else if (dx < LP_MY_X) port = 5'b10000;
        else if (dy > LP_MY_Y) port = 5'b00010;
        else if (dy < LP_MY_Y) port = 5'b01000;
        else                   port = 5'b00001;
        return port;
    endfunction

    state_t                r_state;
    logic [4:0]            r_req;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_tail_read;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_drop_cnt;

    state_t                w_state_nxt;
    logic                  w_buf_read;
    logic                  w_hs;
    logic                  w_grant;
    logic [1:0]            w_in_type;
    logic [1:0]            w_out_type;
    logic [COORD_W-1:0]    w_dest_x;
    logic [COORD_W-1:0]    w_dest_y;

    assign w_hs       = r_out_valid && bus.out_ready_i;
    assign w_grant    = ((bus.gnt_i & r_req) != 5'b00000);
    assign w_in_type  = bus.buf_data_i[DATA_WIDTH-1 -: 2];
    assign w_out_type = r_out_data[DATA_WIDTH-1 -: 2];
    assign w_dest_x   = bus.buf_data_i[DATA_WIDTH-3 -: COORD_W];
    assign w_dest_y   = bus.buf_data_i[DATA_WIDTH-3-COORD_W -: COORD_W];

    // Next-state and pop strobe; the pop is suppressed while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_read  = 1'b0;
        if (reset) begin
            w_state_nxt = ST_IDLE;
            w_buf_read  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_buf_read = !bus.buf_empty_i;
                    if (w_buf_read && is_head(w_in_type)) w_state_nxt = ST_ROUTE;
                    else                                  w_state_nxt = ST_IDLE;
                end
                ST_ROUTE: begin
                    if (w_grant) w_state_nxt = ST_FWD;
                    else         w_state_nxt = ST_ROUTE;
                end
                ST_FWD: begin
                    w_buf_read = !r_tail_read && !bus.buf_empty_i &&
                                 (!r_out_valid || bus.out_ready_i);
                    if (w_hs && is_last(w_out_type)) w_state_nxt = ST_IDLE;
                    else                             w_state_nxt = ST_FWD;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath, request lock, output register and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req       <= 5'b00000;
            r_hold      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_tail_read <= 1'b0;
            r_busy      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_buf_read) begin
                        if (is_head(w_in_type)) begin
                            r_hold <= bus.buf_data_i;
                            r_req  <= xy_route(w_dest_x, w_dest_y);
                        end else if (r_drop_cnt != CNT_MAX) begin
                            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ROUTE: begin
                    if (w_grant) begin
                        r_out_data  <= r_hold;
                        r_out_valid <= 1'b1;
                        r_tail_read <= (r_hold[DATA_WIDTH-1 -: 2] == TY_SINGLE);
                    end
                end
                ST_FWD: begin
                    // A pop refills the register in the same edge the old flit leaves.
                    if (w_buf_read) begin
                        r_out_data  <= bus.buf_data_i;
                        r_out_valid <= 1'b1;
                        if (w_in_type == TY_TAIL) r_tail_read <= 1'b1;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_hs && is_last(w_out_type)) begin
                        r_req       <= 5'b00000;
                        r_tail_read <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.buf_read_o  = w_buf_read;
    assign bus.req_o       = r_req;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_valid_o = r_out_valid;
    assign bus.busy_o      = r_busy;
    assign bus.drop_cnt_o  = r_drop_cnt;
endmodule

// File: tb/tb_route_ctrl.sv
// Bench for route_ctrl at MY_X=1, MY_Y=1: queue-based buffer model, packet
// scoreboard checked every cycle, plus directed literal checks.
module tb_route_ctrl;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int CNTW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    route_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(CNTW)) bus ();

    route_ctrl #(.DATA_WIDTH(DW), .COORD_W(CW), .MY_X(1), .MY_Y(1), .CNT_W(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] f;
        bit            stray;
    } ent_t;

    ent_t          buf_q[$];
    logic [DW-1:0] exp_out[$];
    bit            hide;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            mdl_drop = 0;
    logic [4:0]    mdl_req  = 5'b00000;
    bit            mdl_busy = 1'b0;
    bit            prev_stall = 1'b0;
    bit            prev_rst   = 1'b1;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Destination from the head flit; X first, then Y, against router (1,1).
    function automatic logic [4:0] exp_route(input logic [DW-1:0] f);
        int dx;
        int dy;
        dx = int'(f[DW-3 -: CW]);
        dy = int'(f[DW-3-CW -: CW]);
        if (dx > 1) return 5'b00100;
        if (dx < 1) return 5'b10000;
        if (dy > 1) return 5'b00010;
        if (dy < 1) return 5'b01000;
        return 5'b00001;
    endfunction

    function automatic bit is_last_f(input logic [DW-1:0] f);
        return (f[DW-1 -: 2] == 2'b00) || (f[DW-1 -: 2] == 2'b11);
    endfunction

    function automatic bit is_head_f(input logic [DW-1:0] f);
        return (f[DW-1] == 1'b0);
    endfunction

    task automatic refresh();
        bus.buf_empty_i = hide || (buf_q.size() == 0);
        if (buf_q.size() != 0) bus.buf_data_i = buf_q[0].f;
        else                   bus.buf_data_i = '0;
    endtask

    task automatic push_pkt(input logic [DW-1:0] f);
        ent_t e;
        e.f = f;
        e.stray = 1'b0;
        buf_q.push_back(e);
        exp_out.push_back(f);
        refresh();
    endtask

    task automatic push_stray(input logic [DW-1:0] f);
        ent_t e;
        e.f = f;
        e.stray = 1'b1;
        buf_q.push_back(e);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy_o && buf_q.size() == 0) break;
            tick();
        end
        chk(nm, {31'd0, bus.busy_o}, 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        refresh();
    end

    // Per-cycle compare against the packet-level model, then advance the model.
    always @(negedge clk) begin : cmp
        ent_t          e;
        logic [DW-1:0] x;
        bit            pop;
        bit            hs;
        chk("req_o", {27'd0, bus.req_o}, {27'd0, mdl_req});
        chk("busy_o", {31'd0, bus.busy_o}, {31'd0, mdl_busy});
        chk("drop_cnt_o", {24'd0, bus.drop_cnt_o}, mdl_drop);
        chk("valid_outside_pkt", {31'd0, bus.out_valid_o && !mdl_busy}, 32'd0);
        chk("read_on_empty", {31'd0, bus.buf_read_o && bus.buf_empty_i}, 32'd0);
        if (prev_stall && !prev_rst) begin
            chk("stall_valid", {31'd0, bus.out_valid_o}, 32'd1);
            chk("stall_data", {16'd0, bus.out_data_o}, {16'd0, prev_data});
        end
        prev_stall = bus.out_valid_o && !bus.out_ready_i;
        prev_data  = bus.out_data_o;
        prev_rst   = reset;
        if (reset) begin
            mdl_req  = 5'b00000;
            mdl_busy = 1'b0;
            mdl_drop = 0;
        end else begin
            pop = bus.buf_read_o && !bus.buf_empty_i;
            hs  = bus.out_valid_o && bus.out_ready_i;
            if (hs) begin
                if (exp_out.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_flit: got 0x%0h, expected none", bus.out_data_o);
                end else begin
                    x = exp_out.pop_front();
                    chk("out_data", {16'd0, bus.out_data_o}, {16'd0, x});
                    if (is_last_f(x)) begin
                        mdl_req  = 5'b00000;
                        mdl_busy = 1'b0;
                    end
                end
            end
            if (pop && buf_q.size() != 0) begin
                e = buf_q.pop_front();
                if (e.stray) begin
                    if (mdl_drop < 255) mdl_drop++;
                end else if (is_head_f(e.f)) begin
                    mdl_req  = exp_route(e.f);
                    mdl_busy = 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] sf[4];
    logic [4:0]    sr[4];
    bit            done;

    initial begin
        reset = 1'b1;
        hide  = 1'b0;
        bus.gnt_i       = 5'b00000;
        bus.out_ready_i = 1'b1;
        refresh();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_req", {27'd0, bus.req_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_data", {16'd0, bus.out_data_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_drop", {24'd0, bus.drop_cnt_o}, 32'd0);
        chk("rst_read", {31'd0, bus.buf_read_o}, 32'd0);

        // Head (3,1) + body + tail, grant in cycle 2.
        push_pkt(16'h4C41);
        push_pkt(16'h8002);
        push_pkt(16'hC003);
        tick();
        chk("t1_req_c1", {27'd0, bus.req_o}, 32'h04);
        chk("t1_busy_c1", {31'd0, bus.busy_o}, 32'd1);
        tick();
        bus.gnt_i = 5'b00100;
        tick();
        bus.gnt_i = 5'b00000;
        chk("t1_valid_c3", {31'd0, bus.out_valid_o}, 32'd1);
        chk("t1_data_c3", {16'd0, bus.out_data_o}, 32'h4C41);
        tick();
        chk("t1_data_c4", {16'd0, bus.out_data_o}, 32'h8002);
        tick();
        chk("t1_data_c5", {16'd0, bus.out_data_o}, 32'hC003);
        tick();
        chk("t1_req_c6", {27'd0, bus.req_o}, 32'd0);
        chk("t1_busy_c6", {31'd0, bus.busy_o}, 32'd0);
        chk("t1_valid_c6", {31'd0, bus.out_valid_o}, 32'd0);

        // Single-flit packets to L, W, N, S.
        sf[0] = 16'h0441; sr[0] = 5'b00001;
        sf[1] = 16'h0042; sr[1] = 5'b10000;
        sf[2] = 16'h0483; sr[2] = 5'b00010;
        sf[3] = 16'h0404; sr[3] = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            push_pkt(sf[i]);
            tick();
            chk("t2_req", {27'd0, bus.req_o}, {27'd0, sr[i]});
            bus.gnt_i = sr[i];
            tick();
            chk("t2_data", {16'd0, bus.out_data_o}, {16'd0, sf[i]});
            tick();
            bus.gnt_i = 5'b00000;
            chk("t2_idle", {31'd0, bus.busy_o}, 32'd0);
        end

        // Stray body and tail dropped, then saturation.
        push_stray(16'h8000);
        push_stray(16'hC000);
        tick();
        tick();
        chk("t3_drop2", {24'd0, bus.drop_cnt_o}, 32'd2);
        chk("t3_req", {27'd0, bus.req_o}, 32'd0);
        for (int i = 0; i < 256; i++) push_stray(16'h8000);
        repeat (262) tick();
        chk("t3_sat", {24'd0, bus.drop_cnt_o}, 32'd255);

        // Back-pressure pattern 1,0,0,1 with a 2-cycle empty gap.
        push_pkt(16'h4C50);
        push_pkt(16'h8011);
        push_pkt(16'h8012);
        push_pkt(16'h8013);
        push_pkt(16'hC014);
        bus.gnt_i = 5'b00100;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            bus.out_ready_i = ((i % 4) == 0) || ((i % 4) == 3);
            hide = (i == 6) || (i == 7);
            refresh();
            tick();
            done = (exp_out.size() == 0) && !bus.busy_o;
        end
        chk("t4_drained", {31'd0, done}, 32'd1);
        bus.out_ready_i = 1'b1;
        hide = 1'b0;
        bus.gnt_i = 5'b00000;
        refresh();

        // Withheld grant, then a mismatching grant, then the right one.
        push_pkt(16'h4C60);
        push_pkt(16'hC061);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_no_out", {31'd0, bus.out_valid_o}, 32'd0);
            tick();
        end
        bus.gnt_i = 5'b00001;
        tick();
        chk("t5_wrong_gnt", {31'd0, bus.out_valid_o}, 32'd0);
        chk("t5_req_held", {27'd0, bus.req_o}, 32'h04);
        bus.gnt_i = 5'b00100;
        tick();
        chk("t5_fwd_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("t5_fwd_data", {16'd0, bus.out_data_o}, 32'h4C60);
        bus.gnt_i = 5'b00000;
        wait_idle("t5_idle");

        // Reset during forwarding, then a fresh packet.
        push_pkt(16'h4C70);
        push_pkt(16'h8071);
        push_pkt(16'h8072);
        push_pkt(16'hC073);
        bus.gnt_i = 5'b00100;
        repeat (4) tick();
        reset = 1'b1;
        buf_q.delete();
        exp_out.delete();
        bus.gnt_i = 5'b00000;
        refresh();
        tick();
        reset = 1'b0;
        chk("t6_req", {27'd0, bus.req_o}, 32'd0);
        chk("t6_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("t6_busy", {31'd0, bus.busy_o}, 32'd0);
        push_pkt(16'h0483);
        tick();
        chk("t6_new_req", {27'd0, bus.req_o}, 32'h02);
        bus.gnt_i = 5'b00010;
        tick();
        chk("t6_new_data", {16'd0, bus.out_data_o}, 32'h0483);
        bus.gnt_i = 5'b00000;
        wait_idle("t6_idle");

        tick();
        chk("exp_out_drained", exp_out.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
